// File: rtl/shift_arb_ctrl_if.sv
// Bus between the two requesters and the shift_arb_ctrl sequencer.
// Optional build macro SHIFT_PARITY_EN affects the sequencer only; this bus is unchanged.
interface shift_arb_ctrl_if #(
    parameter int WIDTH = 4
);
    // Handshake: reqN is a level; the edge that accepts it is followed by a
    // one-cycle gntN pulse, and dinN is captured on that same edge.
    // sout is meaningful only while sout_valid=1.
    // done pulses for one cycle once the word (plus parity, if built in) has gone out.
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             gnt0;
    logic             gnt1;
    logic             owner;
    logic             busy;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output req0, req1, din0, din1,
        input  gnt0, gnt1, owner, busy, sout, sout_valid, done
    );

    modport slave (
        input  req0, req1, din0, din1,
        output gnt0, gnt1, owner, busy, sout, sout_valid, done
    );
endinterface

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter and MSB-first serializer for two requesters sharing one shift path.
// Define SHIFT_PARITY_EN to append an even-parity bit after each word.
module shift_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             r,
    shift_arb_ctrl_if.slave  bus,
    output logic [1:0]       dbg_state
);

`ifdef SHIFT_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;

    logic             winner;
    logic [WIDTH-1:0] win_word;
    logic             div_last;
    logic             bit_last;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;

        // ptr_q names the requester that wins a tie.
        winner   = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
        win_word = winner ? bus.din1 : bus.din0;
        div_last = (div_cnt_q == DW'(DIV - 1));
        bit_last = (bit_cnt_q == CW'(NBITS - 1));

        case (state_q)
            S_IDLE: begin
                owner_d = 1'b0;
                if (bus.req0 || bus.req1) begin
                    state_d   = S_SHIFT;
                    owner_d   = winner;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
`ifdef SHIFT_PARITY_EN
                    shreg_d   = {win_word, ^win_word};
`else
                    shreg_d   = win_word;
`endif
                end
            end
            S_SHIFT: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shreg_d   = shreg_q << 1;
                    if (bit_last) begin
                        state_d = S_DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = ~owner_q;
                owner_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = 1'b0;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        gnt0_d       = (state_q == S_IDLE) && (state_d == S_SHIFT) && !owner_d;
        gnt1_d       = (state_q == S_IDLE) && (state_d == S_SHIFT) &&  owner_d;
        busy_d       = (state_d != S_IDLE);
        sout_valid_d = (state_d == S_SHIFT);
        sout_d       = sout_valid_d && shreg_d[NBITS-1];
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            busy_q       <= 1'b0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            busy_q       <= busy_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = busy_q;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.done       = done_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Directed bench for shift_arb_ctrl: a DIV=1 instance and a DIV=3 instance share clock and reset.
// Expected serial bits include the parity bit when SHIFT_PARITY_EN is defined.
module tb_shift_arb_ctrl;

    localparam int W = 4;
`ifdef SHIFT_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int P = NB + 2;

    logic       clk;
    logic       r;
    logic [1:0] st_a;
    logic [1:0] st_b;
    int         n_cmp;
    int         n_err;

    shift_arb_ctrl_if #(.WIDTH(W)) bus_a ();
    shift_arb_ctrl_if #(.WIDTH(W)) bus_b ();

    shift_arb_ctrl #(.WIDTH(W), .DIV(1)) dut_a (
        .clk       (clk),
        .r         (r),
        .bus       (bus_a.slave),
        .dbg_state (st_a)
    );

    shift_arb_ctrl #(.WIDTH(W), .DIV(3)) dut_b (
        .clk       (clk),
        .r         (r),
        .bus       (bus_b.slave),
        .dbg_state (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [W-1:0] w, input int i);
        if (i < W) return w[W-1-i];
        return ^w;
    endfunction

    // Packing order: {gnt0, gnt1, owner, busy, sout, sout_valid, done}
    function automatic logic [6:0] pk(input logic g0, input logic g1, input logic ow,
                                      input logic bz, input logic so, input logic sv,
                                      input logic dn);
        return {g0, g1, ow, bz, so, sv, dn};
    endfunction

    function automatic logic [6:0] obs_a();
        return {bus_a.gnt0, bus_a.gnt1, bus_a.owner, bus_a.busy,
                bus_a.sout, bus_a.sout_valid, bus_a.done};
    endfunction

    function automatic logic [6:0] obs_b();
        return {bus_b.gnt0, bus_b.gnt1, bus_b.owner, bus_b.busy,
                bus_b.sout, bus_b.sout_valid, bus_b.done};
    endfunction

    task automatic do_reset();
        r = 1'b0;
        tick();
        r = 1'b1;
    endtask

    task automatic test_reset();
        r = 1'b0;
        bus_a.req0 = 1'b1;
        bus_a.din0 = 4'b1011;
        #1;
        n_cmp++;
        if ({obs_a(), st_a} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_async_a: got %b want %b", {obs_a(), st_a}, 9'b0);
        end
        n_cmp++;
        if ({obs_b(), st_b} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_async_b: got %b want %b", {obs_b(), st_b}, 9'b0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({obs_a(), st_a} !== 9'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: got %b want %b", i, {obs_a(), st_a}, 9'b0);
            end
        end
        bus_a.req0 = 1'b0;
        r = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] w;
        logic [6:0]   exp;
        w = 4'b1011;
        bus_a.din0 = w;
        bus_a.req0 = 1'b1;
        tick();
        bus_a.req0 = 1'b0;
        bus_a.din0 = 4'b0000;
        for (int t = 0; t <= NB + 1; t++) begin
            if (t < NB)       exp = pk(t == 0, 1'b0, 1'b0, 1'b1, exp_bit(w, t), 1'b1, 1'b0);
            else if (t == NB) exp = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            else              exp = 7'b0;
            n_cmp++;
            if (obs_a() !== exp) begin
                n_err++;
                $display("FAIL basic t%0d: got %b want %b", t, obs_a(), exp);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [6:0]   exp;
        logic [W-1:0] w;
        logic         own;
        int           ph;
        do_reset();
        bus_a.din0 = 4'b1100;
        bus_a.din1 = 4'b0011;
        bus_a.req0 = 1'b1;
        bus_a.req1 = 1'b1;
        tick();
        for (int t = 0; t < 3 * P; t++) begin
            ph  = t % P;
            own = ((t / P) == 1);
            w   = own ? 4'b0011 : 4'b1100;
            if (ph < NB)       exp = pk(ph == 0 && !own, ph == 0 && own, own, 1'b1, exp_bit(w, ph), 1'b1, 1'b0);
            else if (ph == NB) exp = pk(1'b0, 1'b0, own, 1'b1, 1'b0, 1'b0, 1'b1);
            else               exp = 7'b0;
            n_cmp++;
            if (obs_a() !== exp) begin
                n_err++;
                $display("FAIL round_robin t%0d: got %b want %b", t, obs_a(), exp);
            end
            if (t == 3 * P - 1) begin
                bus_a.req0 = 1'b0;
                bus_a.req1 = 1'b0;
            end
            tick();
        end
        n_cmp++;
        if ({obs_a(), st_a} !== 9'b0) begin
            n_err++;
            $display("FAIL round_robin_idle: got %b want %b", {obs_a(), st_a}, 9'b0);
        end
    endtask

    task automatic test_div3();
        logic [W-1:0] w;
        logic [6:0]   exp;
        w = 4'b1001;
        bus_b.din1 = w;
        bus_b.req1 = 1'b1;
        tick();
        bus_b.req1 = 1'b0;
        bus_b.din1 = 4'b1111;
        for (int t = 0; t <= NB * 3 + 1; t++) begin
            if (t < NB * 3)       exp = pk(1'b0, t == 0, 1'b1, 1'b1, exp_bit(w, t / 3), 1'b1, 1'b0);
            else if (t == NB * 3) exp = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            else                  exp = 7'b0;
            n_cmp++;
            if (obs_b() !== exp) begin
                n_err++;
                $display("FAIL div3 t%0d: got %b want %b", t, obs_b(), exp);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        logic [6:0]   exp;
        logic [W-1:0] w;
        logic         own;
        int           ph;
        do_reset();
        // One full req0 transaction so the tie-break pointer moves to req1.
        bus_a.din0 = 4'b1011;
        bus_a.req0 = 1'b1;
        tick();
        bus_a.req0 = 1'b0;
        repeat (P) tick();
        bus_a.din0 = 4'b1110;
        bus_a.req0 = 1'b1;
        tick();
        bus_a.req0 = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (st_a !== 2'd1) begin
            n_err++;
            $display("FAIL abort_pre_state: got %0d want %0d", st_a, 1);
        end
        r = 1'b0;
        #1;
        n_cmp++;
        if ({obs_a(), st_a} !== 9'b0) begin
            n_err++;
            $display("FAIL abort_async: got %b want %b", {obs_a(), st_a}, 9'b0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs_a() !== 7'b0) begin
                n_err++;
                $display("FAIL abort_hold cyc%0d: got %b want %b", i, obs_a(), 7'b0);
            end
        end
        r = 1'b1;
        tick();
        // Tie after reset must go to req0; req1 (0101) is then served in full.
        bus_a.din0 = 4'b1110;
        bus_a.din1 = 4'b0101;
        bus_a.req0 = 1'b1;
        bus_a.req1 = 1'b1;
        tick();
        for (int t = 0; t < 2 * P; t++) begin
            if (t == 0) bus_a.req0 = 1'b0;
            ph  = t % P;
            own = ((t / P) == 1);
            w   = own ? 4'b0101 : 4'b1110;
            if (ph < NB)       exp = pk(ph == 0 && !own, ph == 0 && own, own, 1'b1, exp_bit(w, ph), 1'b1, 1'b0);
            else if (ph == NB) exp = pk(1'b0, 1'b0, own, 1'b1, 1'b0, 1'b0, 1'b1);
            else               exp = 7'b0;
            n_cmp++;
            if (obs_a() !== exp) begin
                n_err++;
                $display("FAIL abort_recover t%0d: got %b want %b", t, obs_a(), exp);
            end
            if (t == 2 * P - 1) bus_a.req1 = 1'b0;
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        bus_a.din0 = '0;
        bus_a.din1 = '0;
        bus_b.req0 = 1'b0;
        bus_b.req1 = 1'b0;
        bus_b.din0 = '0;
        bus_b.din1 = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_div3();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arb_ctrl.md
Name: shift_arb_ctrl

Overview:
Sequencer and arbiter for the team's serial D-flip-flop shift-register datapath. Two requesters share one shift path. The block round-robin arbitrates between them, parallel-loads the winner's word, and shifts it out MSB-first at a programmable bit rate. It signals grant, per-bit valid, busy and completion, and sits between board-level requesters (switches/keys or upstream logic) and the serial output (LED or pin).

Parameters:
WIDTH, 4, bits per word shifted out (>=2).
DIV, 1, clock cycles each bit is held on sout (>=1).

Ports:
clk  input  1  system clock; all state updates on rising edge.
r  input  1  reset; asynchronous, active-low.
req0  input  1  requester 0 request, level.
req1  input  1  requester 1 request, level.
din0  input  WIDTH  requester 0 parallel word, sampled at grant edge.
din1  input  WIDTH  requester 1 parallel word, sampled at grant edge.
gnt0  output  1  one-cycle grant pulse to requester 0.
gnt1  output  1  one-cycle grant pulse to requester 1.
owner  output  1  index of requester being served; valid while busy.
busy  output  1  high in SHIFT and DONE states.
sout  output  1  serial data bit.
sout_valid  output  1  high while sout carries a data bit.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (r=0, asynchronous, no clk needed): state=IDLE; gnt0=gnt1=owner=busy=sout=sout_valid=done=0; shift reg, bit counter and divider cleared; round-robin pointer set to prefer req0.
- States: IDLE, SHIFT, DONE.
- IDLE: all outputs 0. On a clock edge with req0|req1 high:
  - Winner is the single requester if only one is asserted.
  - If both are asserted, winner is the pointer's preferred requester.
  - On that edge: shreg<=din_winner, owner<=winner, bit counter<=0, divider<=0, state<=SHIFT.
- SHIFT:
  - First SHIFT cycle: gnt_winner=1 for exactly that cycle.
  - busy=1, sout_valid=1, sout=shreg[WIDTH-1].
  - Divider counts 0..DIV-1. At count DIV-1: shreg shifts left (0 fills LSB), bit counter increments, divider resets.
  - After the last bit has been held DIV cycles: state<=DONE.
  - Total SHIFT duration is exactly WIDTH*DIV cycles.
- DONE: one cycle; done=1, busy=1, sout_valid=0, sout=0, owner held. Pointer<=~owner, so the other requester is preferred next. state<=IDLE.
- Latency: req sampled at edge k; first bit on sout in cycle after edge k; done in cycle WIDTH*DIV+1 after edge k. Earliest next grant is the edge ending the IDLE cycle after DONE, so back-to-back transactions are separated by one IDLE cycle.
- Changes to req or din after the grant edge are ignored; the transaction always completes.
- A request held continuously is re-served in round-robin turn; nothing is queued beyond the level-sensitive req.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately to reset values; there is no done pulse and the partial word is discarded.

Optional Feature:
SHIFT_PARITY_EN
- Defined: after the WIDTH data bits, one extra bit equal to even parity (XOR of the loaded word) is shifted out, held DIV cycles with sout_valid=1. SHIFT lasts (WIDTH+1)*DIV cycles; done is delayed accordingly.
- Undefined: no parity bit; SHIFT lasts exactly WIDTH*DIV cycles.

Test Plan:
- Reset: drive r=0 mid-idle with req0=1 -> all outputs 0 with no clock edge; no grant while r=0.
- WIDTH=4, DIV=1, req0=1, din0=1011 -> gnt0 high 1 cycle; sout_valid high 4 cycles with sout=1,0,1,1; owner=0; done high in 5th cycle after grant edge; then IDLE.
- req0=req1=1 held after reset, din0=1100, din1=0011 -> served order 0,1,0 (round-robin); outputs 1100 then 0011 then 1100, each followed by done and one IDLE cycle.
- DIV=3, req1=1, din1=1001 -> each bit held 3 cycles (sout=1 x3, 0 x3, 0 x3, 1 x3); sout_valid high 12 cycles; done on cycle 13.
- Reset pulse after 2 bits of din0=1110 -> outputs 0 immediately, no done; after release, req1=1, din1=0101 -> full 0101 sequence, pointer prefers req0 again.
- SHIFT_PARITY_EN defined, din0=1011 -> sout=1,0,1,1,1 over 5 valid cycles; done on 6th cycle.
